// File: rtl/bus_decoder_pkg.sv
// Shared types and constants for the CPU-to-slave bus decoder.
package bus_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'h0000_0000;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    localparam int TMO_W = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/bus_decoder_if.sv
// CPU-side request/response and slave-side select signals of the bus decoder.
interface bus_decoder_if #(
    parameter int unsigned NUM_SLV = 8
);
    // Handshake: cpu_valid is sampled only while the decoder is idle and the request
    // fields are ignored once accepted; cpu_ready is a one-cycle completion pulse with
    // cpu_rdata valid alongside it; slv_cs stays high until the selected slv_ready is 1.
    logic                   cpu_valid;
    logic [31:0]            cpu_addr;
    logic [3:0]             cpu_wstrb;
    logic [31:0]            cpu_wdata;
    logic                   cpu_ready;
    logic [31:0]            cpu_rdata;
    logic [NUM_SLV-1:0]     slv_cs;
    logic [3:0]             slv_wstrb;
    logic [31:0]            slv_addr;
    logic [31:0]            slv_wdata;
    logic [NUM_SLV*32-1:0]  slv_rdata;
    logic [NUM_SLV-1:0]     slv_ready;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, slv_rdata, slv_ready,
        output cpu_ready, cpu_rdata, slv_cs, slv_wstrb, slv_addr, slv_wdata
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, slv_rdata, slv_ready,
        input  cpu_ready, cpu_rdata, slv_cs, slv_wstrb, slv_addr, slv_wdata
    );

endinterface

// File: rtl/bus_timeout.sv
// 16-bit access watchdog: cleared on entry to an access, counts enabled cycles.
module bus_timeout
    import bus_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserts during the TIMEOUT-th enabled cycle, so the access ends on that edge.
    assign expired = en && (({1'b0, count_q} + (TMO_W+1)'(1)) == (TMO_W+1)'(TIMEOUT));

endmodule

// File: rtl/bus_decoder.sv
// Address decoder and access sequencer between one CPU port and NUM_SLV slave ports.
module bus_decoder
    import bus_decoder_pkg::*;
#(
    parameter int unsigned           NUM_SLV  = 8,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*32-1:0] SLV_MASK = '0,
    parameter logic [NUM_SLV-1:0]    PROT_VEC = '0,
    parameter int unsigned           TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    bus_decoder_if.slave         bus,
    input  logic                 force_trap,
    input  logic                 fw_app_mode,
    output logic                 err_unmapped,
    output logic                 err_prot,
    output logic                 err_timeout,
    output logic [ERR_CNT_W-1:0] err_count,
    output state_e               dbg_state
);

    state_e                 state_q, state_d;
    logic                   cpu_ready_q, cpu_ready_d;
    logic [31:0]            cpu_rdata_q, cpu_rdata_d;
    logic [NUM_SLV-1:0]     slv_cs_q, slv_cs_d;
    logic [3:0]             slv_wstrb_q, slv_wstrb_d;
    logic [31:0]            slv_addr_q, slv_addr_d;
    logic [31:0]            slv_wdata_q, slv_wdata_d;
    logic                   err_unmapped_q, err_unmapped_d;
    logic                   err_prot_q, err_prot_d;
    logic                   err_timeout_q, err_timeout_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    logic [NUM_SLV-1:0]     hit_vec;
    logic [NUM_SLV-1:0]     sel_onehot;
    logic [31:0]            rd_mux;
    logic                   ready_sel;
    logic                   tmo_clr;
    logic                   tmo_en;
    logic                   tmo_expired;

    // Isolating the lowest set bit of the hit vector gives lowest-index priority.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            hit_vec[i] = ((bus.cpu_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]);
        end
        sel_onehot = hit_vec & (~hit_vec + NUM_SLV'(1));
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (slv_cs_q[i]) begin
                rd_mux = rd_mux | bus.slv_rdata[i*32 +: 32];
            end
        end
        ready_sel = |(bus.slv_ready & slv_cs_q);
    end

    assign tmo_en = (state_q == ST_ACCESS);

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d        = state_q;
        cpu_ready_d    = 1'b0;
        cpu_rdata_d    = '0;
        slv_cs_d       = slv_cs_q;
        slv_wstrb_d    = slv_wstrb_q;
        slv_addr_d     = slv_addr_q;
        slv_wdata_d    = slv_wdata_q;
        err_unmapped_d = 1'b0;
        err_prot_d     = 1'b0;
        err_timeout_d  = 1'b0;
        tmo_clr        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_valid) begin
                    slv_addr_d  = bus.cpu_addr;
                    slv_wstrb_d = bus.cpu_wstrb;
                    slv_wdata_d = bus.cpu_wdata;
                    tmo_clr     = 1'b1;
                    if (force_trap) begin
                        state_d     = ST_RESP;
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = ILLEGAL_INSTRUCTION;
                    end else if (hit_vec == '0) begin
                        state_d        = ST_RESP;
                        cpu_ready_d    = 1'b1;
                        err_unmapped_d = 1'b1;
                    end else if (((sel_onehot & PROT_VEC) != '0) && fw_app_mode) begin
                        state_d     = ST_RESP;
                        cpu_ready_d = 1'b1;
                        err_prot_d  = 1'b1;
                    end else begin
                        state_d  = ST_ACCESS;
                        slv_cs_d = sel_onehot;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready is checked first so it wins over a coincident timeout.
                if (ready_sel) begin
                    state_d     = ST_RESP;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = rd_mux;
                    slv_cs_d    = '0;
                end else if (tmo_expired) begin
                    state_d       = ST_RESP;
                    cpu_ready_d   = 1'b1;
                    err_timeout_d = 1'b1;
                    slv_cs_d      = '0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                slv_cs_d = '0;
            end
        endcase

        err_count_d = err_count_q;
        if (err_unmapped_d || err_prot_d || err_timeout_d) begin
            err_count_d = sat_inc(err_count_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cpu_ready_q    <= 1'b0;
            cpu_rdata_q    <= '0;
            slv_cs_q       <= '0;
            slv_wstrb_q    <= '0;
            slv_addr_q     <= '0;
            slv_wdata_q    <= '0;
            err_unmapped_q <= 1'b0;
            err_prot_q     <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            cpu_ready_q    <= cpu_ready_d;
            cpu_rdata_q    <= cpu_rdata_d;
            slv_cs_q       <= slv_cs_d;
            slv_wstrb_q    <= slv_wstrb_d;
            slv_addr_q     <= slv_addr_d;
            slv_wdata_q    <= slv_wdata_d;
            err_unmapped_q <= err_unmapped_d;
            err_prot_q     <= err_prot_d;
            err_timeout_q  <= err_timeout_d;
            err_count_q    <= err_count_d;
        end
    end

    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.slv_cs    = slv_cs_q;
    assign bus.slv_wstrb = slv_wstrb_q;
    assign bus.slv_addr  = slv_addr_q;
    assign bus.slv_wdata = slv_wdata_q;
    assign err_unmapped  = err_unmapped_q;
    assign err_prot      = err_prot_q;
    assign err_timeout   = err_timeout_q;
    assign err_count     = err_count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Scoreboard bench for bus_decoder: directed requests push expected responses, a monitor checks them.
module tb_bus_decoder;
    import bus_decoder_pkg::*;

    localparam int unsigned NSLV = 4;
    localparam logic [NSLV*32-1:0] BASE = {32'h5000_0000, 32'h4000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NSLV*32-1:0] MASK = {32'hF000_0000, 32'hC000_0000, 32'hF000_0000, 32'hF000_0000};
    localparam logic [NSLV-1:0]    PROT = 4'b0010;
    localparam logic [NSLV*32-1:0] RDATA = {32'hCAFE_0003, 32'hDEAD_BEEF, 32'h1111_0001, 32'h0000_AAA0};

    typedef struct packed {
        logic [31:0] rdata;
        logic [2:0]  errs;     // {unmapped, prot, timeout}
        logic [7:0]  cnt;
        logic [3:0]  cs;
        logic [7:0]  cs_cyc;
        logic [7:0]  lat;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_decoder_if #(.NUM_SLV(NSLV)) bus ();
    logic       force_trap;
    logic       fw_app_mode;
    logic       err_unmapped;
    logic       err_prot;
    logic       err_timeout;
    logic [7:0] err_count;
    state_e     dbg_state;

    bus_decoder #(
        .NUM_SLV  (NSLV),
        .SLV_BASE (BASE),
        .SLV_MASK (MASK),
        .PROT_VEC (PROT),
        .TIMEOUT  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .force_trap   (force_trap),
        .fw_app_mode  (fw_app_mode),
        .err_unmapped (err_unmapped),
        .err_prot     (err_prot),
        .err_timeout  (err_timeout),
        .err_count    (err_count),
        .dbg_state    (dbg_state)
    );

    // ---------------- slave model ----------------
    logic [7:0] ready_delay = 8'd0;
    logic       never_ready = 1'b0;
    logic [7:0] model_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) model_cnt <= 8'd0;
        else if (bus.slv_cs != '0) model_cnt <= model_cnt + 8'd1;
        else model_cnt <= 8'd0;
    end

    assign bus.slv_ready = (never_ready || (model_cnt < ready_delay)) ? '0 : bus.slv_cs;
    assign bus.slv_rdata = RDATA;

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_err_cnt = 8'd0;
    bit inflight = 1'b0;
    int lat = 0;
    int cs_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            inflight = 1'b0;
            lat      = 0;
            cs_cyc   = 0;
        end else begin
            if (inflight) begin
                lat++;
            end else if (bus.cpu_valid) begin
                inflight = 1'b1;
                lat      = 0;
                cs_cyc   = 0;
            end
            if (bus.slv_cs != '0) begin
                cs_cyc++;
                if (exp_q.size() == 0) begin
                    check("spurious_cs", 64'(bus.slv_cs), 64'd0);
                end else begin
                    e = exp_t'(exp_q[0]);
                    check("slv_cs", 64'(bus.slv_cs), 64'(e.cs));
                    check("slv_addr", 64'(bus.slv_addr), 64'(e.addr));
                    check("slv_wstrb_wdata", 64'({bus.slv_wstrb, bus.slv_wdata}), 64'({e.wstrb, e.wdata}));
                end
            end
            if (bus.cpu_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ready", 64'(bus.cpu_ready), 64'd0);
                end else begin
                    e = exp_t'(exp_q.pop_front());
                    check("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.rdata));
                    check("err_pulses", 64'({err_unmapped, err_prot, err_timeout}), 64'(e.errs));
                    check("err_count", 64'(err_count), 64'(e.cnt));
                    check("cs_cycles", 64'(cs_cyc), 64'(e.cs_cyc));
                    check("latency", 64'(lat), 64'(e.lat));
                end
                inflight = 1'b0;
            end else begin
                check("idle_outputs", 64'({bus.cpu_rdata, err_unmapped, err_prot, err_timeout}), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL completion_wait: got no cpu_ready within 50 cycles, expected one");
            exp_q.delete();
            inflight = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                            input logic [31:0] e_rdata, input logic [2:0] e_errs, input logic [3:0] e_cs,
                            input logic [7:0] e_cs_cyc, input logic [7:0] e_lat);
        exp_t e;
        if (e_errs != 3'b000 && exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
        e.rdata  = e_rdata;
        e.errs   = e_errs;
        e.cnt    = exp_err_cnt;
        e.cs     = e_cs;
        e.cs_cyc = e_cs_cyc;
        e.lat    = e_lat;
        e.addr   = addr;
        e.wstrb  = wstrb;
        e.wdata  = wdata;
        exp_q.push_back(EXP_W'(e));
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                             input logic trap, input logic app);
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = addr;
        bus.cpu_wstrb = wstrb;
        bus.cpu_wdata = wdata;
        force_trap    = trap;
        fw_app_mode   = app;
    endtask

    // Scrambles the request after acceptance; the decoder must ignore it.
    task automatic scramble_req(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                                input logic trap, input logic app);
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = ~addr;
        bus.cpu_wstrb = ~wstrb;
        bus.cpu_wdata = ~wdata;
        force_trap    = ~trap;
        fw_app_mode   = ~app;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                         input logic trap, input logic app, input logic [7:0] delay, input logic never,
                         input logic [31:0] e_rdata, input logic [2:0] e_errs, input logic [3:0] e_cs,
                         input logic [7:0] e_cs_cyc, input logic [7:0] e_lat);
        wait_done();
        @(posedge clk);
        #1;
        ready_delay = delay;
        never_ready = never;
        drive_req(addr, wstrb, wdata, trap, app);
        push_exp(addr, wstrb, wdata, e_rdata, e_errs, e_cs, e_cs_cyc, e_lat);
        @(posedge clk);
        #1;
        scramble_req(addr, wstrb, wdata, trap, app);
        wait_done();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wstrb = 4'h0;
        bus.cpu_wdata = 32'h0;
        force_trap    = 1'b0;
        fw_app_mode   = 1'b0;

        #12;
        check("rst_cpu", 64'({bus.cpu_ready, bus.cpu_rdata}), 64'd0);
        check("rst_slv", 64'({bus.slv_cs, bus.slv_wstrb, bus.slv_wdata}), 64'd0);
        check("rst_slv_addr", 64'(bus.slv_addr), 64'd0);
        check("rst_err", 64'({err_unmapped, err_prot, err_timeout, err_count}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #2 reset = 1'b0;

        //     addr          wstrb wdata          trp app dly nvr  rdata          errs    cs       cyc lat
        issue(32'h4000_0004, 4'h0, 32'h0000_0000, 0, 0, 0, 0, 32'hDEAD_BEEF, 3'b000, 4'b0100, 1, 2);
        issue(32'h0000_0100, 4'hF, 32'h1234_5678, 0, 0, 3, 0, 32'h0000_AAA0, 3'b000, 4'b0001, 4, 5);
        issue(32'h8000_0000, 4'h0, 32'h0000_0000, 0, 0, 0, 0, 32'h0000_0000, 3'b100, 4'b0000, 0, 1);
        issue(32'h1000_0010, 4'h0, 32'h0000_0000, 0, 1, 0, 0, 32'h0000_0000, 3'b010, 4'b0000, 0, 1);
        issue(32'h1000_0010, 4'h0, 32'h0000_0000, 0, 0, 1, 0, 32'h1111_0001, 3'b000, 4'b0010, 2, 3);
        issue(32'h5000_0000, 4'h0, 32'h0000_0000, 0, 0, 0, 0, 32'hDEAD_BEEF, 3'b000, 4'b0100, 1, 2);
        issue(32'h0000_0200, 4'h0, 32'h0000_0000, 0, 0, 0, 1, 32'h0000_0000, 3'b001, 4'b0001, 4, 5);
        issue(32'h4000_0000, 4'h0, 32'h0000_0000, 1, 0, 0, 0, 32'h0000_0000, 3'b000, 4'b0000, 0, 1);
        issue(32'hC000_0000, 4'h0, 32'h0000_0000, 1, 0, 0, 0, 32'h0000_0000, 3'b000, 4'b0000, 0, 1);
        issue(32'h1000_0000, 4'h0, 32'h0000_0000, 1, 1, 0, 0, 32'h0000_0000, 3'b000, 4'b0000, 0, 1);
        issue(32'h7FFF_FFFC, 4'h3, 32'hA5A5_0F0F, 0, 0, 2, 0, 32'hDEAD_BEEF, 3'b000, 4'b0100, 3, 4);

        for (int i = 0; i < 300; i++) begin
            issue(32'h8000_0000 + 32'(i), 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 3'b100, 4'b0000, 0, 1);
        end
        @(negedge clk);
        check("err_count_sat", 64'(err_count), 64'd255);

        // Reset during the second ACCESS cycle of a stalled access.
        wait_done();
        @(posedge clk);
        #1;
        ready_delay = 8'd0;
        never_ready = 1'b1;
        drive_req(32'h0000_0300, 4'h0, 32'h0, 1'b0, 1'b0);
        push_exp(32'h0000_0300, 4'h0, 32'h0, 32'h0, 3'b000, 4'b0001, 8'd0, 8'd0);
        @(posedge clk);
        #1;
        scramble_req(32'h0000_0300, 4'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_access_cs", 64'(bus.slv_cs), 64'd0);
        check("rst_access_ready", 64'(bus.cpu_ready), 64'd0);
        check("rst_access_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_access_errcnt", 64'(err_count), 64'd0);
        exp_q.delete();
        exp_err_cnt = 8'd0;
        never_ready = 1'b0;
        repeat (3) @(posedge clk);

        // Request already pending when reset releases: accepted on the first edge.
        #1;
        drive_req(32'h4000_0000, 4'h0, 32'h0, 1'b0, 1'b0);
        push_exp(32'h4000_0000, 4'h0, 32'h0, 32'hDEAD_BEEF, 3'b000, 4'b0100, 8'd1, 8'd2);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        scramble_req(32'h4000_0000, 4'h0, 32'h0, 1'b0, 1'b0);
        wait_done();
        issue(32'hC000_0000, 4'h0, 32'h0, 0, 0, 0, 0, 32'h0, 3'b100, 4'b0000, 0, 1);
        wait_done();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got no end of stimulus by %0t, expected completion", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
